// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: tear-free double-buffered value, per-slot
// ghost blanking, BCD/hex decode and leading-zero suppression.
module seg7_scan_driver #(
  parameter int DIGITS         = 6,
  parameter int SCAN_DIV       = 5000,
  parameter int BLANK_CYC      = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic                  lz_blank,
  input  logic                  blank_all,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] DIG_OFF  = {DIGITS{DIG_ACTIVE_LOW}};

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] shadow_val, active_val;
  logic [DIGITS-1:0]   shadow_dp, active_dp;
  logic                pending;
  logic                boundary;

  assign boundary = (cnt == CNT_LAST) && (idx == IDX_LAST);

  function automatic logic [6:0] decode(input logic [3:0] nib, input logic hex);
    logic [6:0] p;
    case (nib)
      4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
      4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
      4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
      4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
    endcase
    if (!hex && nib > 4'h9) p = 7'h40;
    return p;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // load is a one-cycle strobe with no back-pressure: it is accepted on every
  // cycle it is high, the latest one wins, and the display only picks it up at
  // a frame boundary (directly, when the strobe lands on the boundary itself).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
    end else if (load && boundary) begin
      shadow_val <= value;
      shadow_dp  <= dp_in;
      active_val <= value;
      active_dp  <= dp_in;
      pending    <= 1'b0;
    end else if (load) begin
      shadow_val <= value;
      shadow_dp  <= dp_in;
      pending    <= 1'b1;
    end else if (boundary && pending) begin
      active_val <= shadow_val;
      active_dp  <= shadow_dp;
      pending    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) frame_done <= 1'b0;
    else          frame_done <= boundary;
  end

  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_lz;
  logic              zero_run;
  logic [DIGITS-1:0] lz_mask;
  logic [DIGITS-1:0] onehot;
  logic [6:0]        pat;
  logic              show;

  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    // Walk down from the top digit; digit 0 always stays lit.
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run   = zero_run & (active_val[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_run;
    end
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    onehot  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      onehot[i] = (idx == IW'(i));
      if (idx == IW'(i)) begin
        cur_nib = active_val[4*i +: 4];
        cur_dp  = active_dp[i];
        cur_lz  = lz_mask[i];
      end
    end
    pat = decode(cur_nib, hex_mode);
    if (lz_blank && cur_lz) pat = 7'h00;
    show = (int'(cnt) >= BLANK_CYC) && !blank_all;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg    <= SEG_OFF;
      dp     <= SEG_ACTIVE_LOW;
      dig_en <= DIG_OFF;
    end else if (show) begin
      seg    <= pat ^ SEG_OFF;
      dp     <= cur_dp ^ SEG_ACTIVE_LOW;
      dig_en <= onehot ^ DIG_OFF;
    end else begin
      seg    <= SEG_OFF;
      dp     <= SEG_ACTIVE_LOW;
      dig_en <= DIG_OFF;
    end
  end

endmodule
